grid_query_server: RTL
======================

// Module: grid_query_server
// PURPOSE
//  Responder side of the grid-lookup interface. Player movement logic and the renderer
//  send a (grid_x, grid_y) request and wait for an ack with the cell type. The server
//  arbitrates between two requesters and reads the map memory (synchronous RAM/ROM).
//  It returns the 3-bit cell code and forces a solid code for out-of-map coordinates.
// PARAMETERS
//  MAP_W         40      map width in cells (valid x: 0..MAP_W-1)
//  MAP_H         30      map height in cells (valid y: 0..MAP_H-1)
//  ADDR_W        11      map memory address width (must hold MAP_W*MAP_H-1)
//  READ_LATENCY  2       edges from mem_addr change to matching mem_data (>=1)
//  OOB_CODE      3'b111  cell code returned for out-of-bounds coordinates
// PORTS
//  clock       in   1       system clock
//  reset       in   1       asynchronous, active-high reset
//  req_a       in   1       requester A (player updater) request, level
//  grid_x_a    in   6       requester A cell x
//  grid_y_a    in   5       requester A cell y
//  ack_a       out  1       one-cycle pulse: grid_out_a valid
//  grid_out_a  out  3       cell code for A's last request (held until next A ack)
//  req_b, grid_x_b, grid_y_b, ack_b, grid_out_b: same as A, for requester B (renderer)
//  mem_addr    out  ADDR_W  registered map memory read address
//  mem_data    in   3       map memory read data
//  busy        out  1       high in every state except IDLE
// BEHAVIOUR
//  Reset (async): state=IDLE; ack_a/ack_b=0; grid_out_a/b=0; mem_addr=0; busy=0;
//   last_grant=B (so A wins the first tie). An in-flight request is dropped; a req still
//   high after reset release starts a new transaction.
//  FSM: IDLE -> READ -> RESPOND -> IDLE.
//   IDLE: if req_a|req_b at edge N: pick owner and latch its x/y. Load mem_addr and
//    set the latency counter to READ_LATENCY-1. Go to READ.
//    Arbitration: only one req high -> that one wins; both high -> the one not in last_grant.
//   READ: decrement counter each edge; when counter==0, at that edge capture the result
//    into grid_out_<owner>, set ack_<owner>=1, update last_grant, go to RESPOND.
//    The capture edge is N+READ_LATENCY.
//   RESPOND: ack high for exactly this one cycle; next edge clears ack and returns to IDLE.
//  Latency: ack rises READ_LATENCY edges after the sampling edge. A request
//   occupies READ_LATENCY+1 cycles, so back-to-back throughput is one request per
//   READ_LATENCY+2 cycles, including the IDLE sample cycle.
//  Handshake: requester holds req high until it sees ack, then drops req on the edge
//   ending the ack cycle. x/y may change after the grant edge (latched). req remaining
//   high in the IDLE cycle after an ack counts as a new request. Non-owner reqs wait
//   with no loss.
//  Address: mem_addr = y*MAP_W + x, computed at ADDR_W bits. No truncation is allowed
//   for in-bounds cells.
//  Bounds: x>=MAP_W or y>=MAP_H -> result is OOB_CODE (mem_data ignored). Memory is
//   still addressed (mem_addr=0) and the latency is identical to an in-bounds read.
//  Only the owner's ack/grid_out change; the other side's grid_out holds its value.
// TESTING
//  1 Reset, req_a=1 x=3 y=2, mem cell 83=3'b001 -> mem_addr=83; ack_a at edge N+2;
//    grid_out_a=001; ack_b never high.
//  2 req_a and req_b rise the same cycle after reset -> A served first, B second. B's
//    ack comes 4 cycles after A's (READ_LATENCY=2). Repeat with both -> B then A.
//  3 req_b x=40 y=0 and x=0 y=30 -> grid_out_b=3'b111 each with normal latency;
//    x=39 y=29 -> mem_addr=1199.
//  4 Assert reset during READ for A -> ack_a stays 0, outputs zero. With req_a held, a
//    fresh transaction completes after release.
//  5 Change grid_x_a one cycle after grant -> result matches the originally latched x.
//  6 READ_LATENCY=1 build: single request -> ack one edge after sampling; busy high
//    exactly 2 cycles.

Source files
------------

// File: rtl/grid_query_server.sv
// grid_query_server: arbitrated responder for grid-cell lookups.
// Two requesters (A = player updater, B = renderer) share one synchronous map
// memory. Each request is served in IDLE -> READ -> RESPOND order with a fixed
// latency. Out-of-map coordinates return OOB_CODE after the same latency.
module grid_query_server #(
  parameter int unsigned MAP_W        = 40,
  parameter int unsigned MAP_H        = 30,
  parameter int unsigned ADDR_W       = 11,
  parameter int unsigned READ_LATENCY = 2,
  parameter logic [2:0]  OOB_CODE     = 3'b111
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_a,
  input  logic [5:0]        grid_x_a,
  input  logic [4:0]        grid_y_a,
  output logic              ack_a,
  output logic [2:0]        grid_out_a,
  input  logic              req_b,
  input  logic [5:0]        grid_x_b,
  input  logic [4:0]        grid_y_b,
  output logic              ack_b,
  output logic [2:0]        grid_out_b,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [2:0]        mem_data,
  output logic              busy
);

  localparam int unsigned CNT_W = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] READ    = 2'd1;
  localparam logic [1:0] RESPOND = 2'd2;

  // owner / last_grant encoding: 0 = requester A, 1 = requester B
  logic [1:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              owner_q, owner_d;
  logic              oob_q, oob_d;
  logic              last_grant_q, last_grant_d;
  logic              ack_a_q, ack_a_d;
  logic              ack_b_q, ack_b_d;
  logic [2:0]        out_a_q, out_a_d;
  logic [2:0]        out_b_q, out_b_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              busy_q, busy_d;

  logic              grant_b_c;
  logic [5:0]        sel_x_c;
  logic [4:0]        sel_y_c;
  logic              sel_oob_c;
  logic [ADDR_W-1:0] lin_addr_c;
  logic [2:0]        result_c;

  // Arbitration, coordinate select, bounds check and linear address
  always_comb begin
    grant_b_c  = req_b && (!req_a || !last_grant_q);
    sel_x_c    = grant_b_c ? grid_x_b : grid_x_a;
    sel_y_c    = grant_b_c ? grid_y_b : grid_y_a;
    sel_oob_c  = (32'(sel_x_c) >= MAP_W) || (32'(sel_y_c) >= MAP_H);
    lin_addr_c = ADDR_W'(sel_y_c) * ADDR_W'(MAP_W) + ADDR_W'(sel_x_c);
    result_c   = oob_q ? OOB_CODE : mem_data;
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    owner_d      = owner_q;
    oob_d        = oob_q;
    last_grant_d = last_grant_q;
    ack_a_d      = 1'b0;
    ack_b_d      = 1'b0;
    out_a_d      = out_a_q;
    out_b_d      = out_b_q;
    addr_d       = addr_q;

    case (state_q)
      IDLE: begin
        if (req_a || req_b) begin
          owner_d = grant_b_c;
          oob_d   = sel_oob_c;
          addr_d  = sel_oob_c ? '0 : lin_addr_c;
          cnt_d   = CNT_W'(READ_LATENCY - 1);
          state_d = READ;
        end
      end
      READ: begin
        if (cnt_q == '0) begin
          if (owner_q) begin
            ack_b_d = 1'b1;
            out_b_d = result_c;
          end else begin
            ack_a_d = 1'b1;
            out_a_d = result_c;
          end
          last_grant_d = owner_q;
          state_d      = RESPOND;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RESPOND: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and output registers; reset drops any in-flight request
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      owner_q      <= 1'b0;
      oob_q        <= 1'b0;
      last_grant_q <= 1'b1;
      ack_a_q      <= 1'b0;
      ack_b_q      <= 1'b0;
      out_a_q      <= '0;
      out_b_q      <= '0;
      addr_q       <= '0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      owner_q      <= owner_d;
      oob_q        <= oob_d;
      last_grant_q <= last_grant_d;
      ack_a_q      <= ack_a_d;
      ack_b_q      <= ack_b_d;
      out_a_q      <= out_a_d;
      out_b_q      <= out_b_d;
      addr_q       <= addr_d;
      busy_q       <= busy_d;
    end
  end

  assign ack_a      = ack_a_q;
  assign ack_b      = ack_b_q;
  assign grid_out_a = out_a_q;
  assign grid_out_b = out_b_q;
  assign mem_addr   = addr_q;
  assign busy       = busy_q;

endmodule
